// File: rtl/controle_escrita_registradores.sv
// -----------------------------------------------------------------------------
// controle_escrita_registradores
//
// Write-port controller for the register file (one write port, no reset of its
// own). Two writeback requesters share that port:
//   A = ULA, B = memória/E-S, arbitrated round-robin.
// Right after reset (when INICIALIZA=1) the block walks every address and writes
// zero, so the register file starts in a known state. While the write
// registers hold a pending write, same-cycle reads of that address are flagged
// as stale for the hazard logic.
//
// Handshake (valid/ready): req_X is valid, pronto_X is ready. A transfer
// happens on a rising clock edge where req_X && pronto_X. The requester keeps
// end_X/dados_X stable while req_X is high and not yet accepted. It may drop
// req_X without a transfer. pronto_X is combinational and never depends on
// anything the requester changes in the same cycle except req_A/req_B.
//
// Ports:
//   clock, reset_n            clock (rising edge), async active-low reset
//   req_A/end_A/dados_A       requester A write request, address, data
//   pronto_A                  grant to A
//   req_B/end_B/dados_B       requester B write request, address, data
//   pronto_B                  grant to B
//   endereco_E/dados/escreve_R registered register-file write port
//   ocupado                   high while the clear sequence runs
//   endereco_L1/endereco_L2   decoder read addresses (RS, RT)
//   conflito_L1/conflito_L2   read would return stale data this cycle
// -----------------------------------------------------------------------------
module controle_escrita_registradores #(
    parameter int NUM_REGS   = 32,
    parameter int END_LARG   = 5,
    parameter int LARGURA    = 32,
    parameter int INICIALIZA = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_A,
    input  logic [END_LARG-1:0] end_A,
    input  logic [LARGURA-1:0]  dados_A,
    output logic                pronto_A,
    input  logic                req_B,
    input  logic [END_LARG-1:0] end_B,
    input  logic [LARGURA-1:0]  dados_B,
    output logic                pronto_B,
    output logic [END_LARG-1:0] endereco_E,
    output logic [LARGURA-1:0]  dados,
    output logic                escreve_R,
    output logic                ocupado,
    input  logic [END_LARG-1:0] endereco_L1,
    input  logic [END_LARG-1:0] endereco_L2,
    output logic                conflito_L1,
    output logic                conflito_L2
);

    typedef enum logic {
        LIMPA = 1'b0,
        OPERA = 1'b1
    } estado_t;

    typedef enum logic {
        ULT_A = 1'b0,
        ULT_B = 1'b1
    } ultimo_t;

    localparam logic [END_LARG-1:0] ULTIMO_END = END_LARG'(NUM_REGS - 1);
    localparam logic [END_LARG-1:0] UM         = END_LARG'(1);
    localparam logic [END_LARG-1:0] ZERO_END   = '0;

    estado_t             estado;
    estado_t             prox_estado;
    ultimo_t             ultimo;
    logic [END_LARG-1:0] contador;
    logic                transf_A;
    logic                transf_B;

    // Next state and grants. Grants are only given in OPERA; on a tie the
    // requester that did not transfer last wins.
    always_comb begin
        prox_estado = estado;
        pronto_A    = 1'b0;
        pronto_B    = 1'b0;
        case (estado)
            LIMPA: begin
                if (contador == ULTIMO_END) begin
                    prox_estado = OPERA;
                end
            end
            OPERA: begin
                if (req_A && (!req_B || ultimo == ULT_B)) begin
                    pronto_A = 1'b1;
                end else if (req_B) begin
                    pronto_B = 1'b1;
                end
            end
            default: prox_estado = OPERA;
        endcase
    end

    assign transf_A = req_A && pronto_A;
    assign transf_B = req_B && pronto_B;
    assign ocupado  = (estado == LIMPA);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado     <= (INICIALIZA != 0) ? LIMPA : OPERA;
            ultimo     <= ULT_B;
            contador   <= '0;
            endereco_E <= '0;
            dados      <= '0;
            escreve_R  <= 1'b0;
        end else begin
            estado <= prox_estado;
            if (estado == LIMPA) begin
                // One zero-write per cycle, address 0 included.
                endereco_E <= contador;
                dados      <= '0;
                escreve_R  <= 1'b1;
                contador   <= contador + UM;
            end else begin
                if (transf_A) begin
                    ultimo <= ULT_A;
                end else if (transf_B) begin
                    ultimo <= ULT_B;
                end
                // Writes to $0 are accepted but never reach the register file.
                if (transf_A && end_A != ZERO_END) begin
                    endereco_E <= end_A;
                    dados      <= dados_A;
                    escreve_R  <= 1'b1;
                end else if (transf_B && end_B != ZERO_END) begin
                    endereco_E <= end_B;
                    dados      <= dados_B;
                    escreve_R  <= 1'b1;
                end else begin
                    escreve_R  <= 1'b0;
                end
            end
        end
    end

    // A read of the address being written this cycle sees the old value.
    // $0 is never stale, even during the clear.
    assign conflito_L1 = escreve_R && (endereco_E == endereco_L1) && (endereco_L1 != ZERO_END);
    assign conflito_L2 = escreve_R && (endereco_E == endereco_L2) && (endereco_L2 != ZERO_END);

endmodule

// File: tb/tb_controle_escrita_registradores.sv
// -----------------------------------------------------------------------------
// Bench for controle_escrita_registradores. One instance clears on reset
// (INICIALIZA=1); a second instance with INICIALIZA=0 shares its inputs and is
// used only to observe the no-clear start-up.
// -----------------------------------------------------------------------------
module tb_controle_escrita_registradores;

    localparam int EW = 5;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic          req_A = 1'b0, req_B = 1'b0;
    logic [EW-1:0] end_A = '0, end_B = '0;
    logic [DW-1:0] dados_A = '0, dados_B = '0;
    logic [EW-1:0] endereco_L1 = '0, endereco_L2 = '0;

    logic          pronto_A, pronto_B, escreve_R, ocupado, conflito_L1, conflito_L2;
    logic [EW-1:0] endereco_E;
    logic [DW-1:0] dados;

    logic          pronto_A2, pronto_B2, escreve_R2, ocupado2, conflito_L1_2, conflito_L2_2;
    logic [EW-1:0] endereco_E2;
    logic [DW-1:0] dados2;

    controle_escrita_registradores #(
        .NUM_REGS(32), .END_LARG(EW), .LARGURA(DW), .INICIALIZA(1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_A(req_A), .end_A(end_A), .dados_A(dados_A), .pronto_A(pronto_A),
        .req_B(req_B), .end_B(end_B), .dados_B(dados_B), .pronto_B(pronto_B),
        .endereco_E(endereco_E), .dados(dados), .escreve_R(escreve_R),
        .ocupado(ocupado),
        .endereco_L1(endereco_L1), .endereco_L2(endereco_L2),
        .conflito_L1(conflito_L1), .conflito_L2(conflito_L2)
    );

    controle_escrita_registradores #(
        .NUM_REGS(32), .END_LARG(EW), .LARGURA(DW), .INICIALIZA(0)
    ) dut_sem_limpa (
        .clock(clock), .reset_n(reset_n),
        .req_A(req_A), .end_A(end_A), .dados_A(dados_A), .pronto_A(pronto_A2),
        .req_B(req_B), .end_B(end_B), .dados_B(dados_B), .pronto_B(pronto_B2),
        .endereco_E(endereco_E2), .dados(dados2), .escreve_R(escreve_R2),
        .ocupado(ocupado2),
        .endereco_L1(endereco_L1), .endereco_L2(endereco_L2),
        .conflito_L1(conflito_L1_2), .conflito_L2(conflito_L2_2)
    );

    // ---------------- scoreboard ----------------
    logic [EW+DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int writes_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_clear();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back({EW'(i), {DW{1'b0}}});
        end
    endtask

    // Monitor: every write presented on the port must match the queue head.
    always @(negedge clock) begin
        logic [EW+DW-1:0] e;
        if (reset_n && escreve_R) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none", endereco_E, dados);
            end else begin
                e = exp_q.pop_front();
                chk("write", {27'b0, endereco_E, dados}, {27'b0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present a request right after a rising edge, hold it until granted.
    task automatic send_a(input logic [EW-1:0] e, input logic [DW-1:0] d);
        bit ok = 0;
        @(posedge clock); #1;
        req_A = 1'b1; end_A = e; dados_A = d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (pronto_A) begin ok = 1; break; end
        end
        chk("a_grant", {63'b0, ok}, 64'd1);
        chk("a_only_one_grant", {63'b0, pronto_B}, 64'd0);
        if (ok && e != '0) exp_q.push_back({e, d});
        @(posedge clock); #1;
        req_A = 1'b0;
    endtask

    task automatic send_b(input logic [EW-1:0] e, input logic [DW-1:0] d);
        bit ok = 0;
        @(posedge clock); #1;
        req_B = 1'b1; end_B = e; dados_B = d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (pronto_B) begin ok = 1; break; end
        end
        chk("b_grant", {63'b0, ok}, 64'd1);
        chk("b_only_one_grant", {63'b0, pronto_A}, 64'd0);
        if (ok && e != '0) exp_q.push_back({e, d});
        @(posedge clock); #1;
        req_B = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_busy;
        int n_conf;
        int w0;
        bit found;

        // Test 1: clear after reset with req_A held high.
        req_A = 1'b1; end_A = 5'd9; dados_A = 32'hA5A5_0009;
        push_clear();
        exp_q.push_back({5'd9, 32'hA5A5_0009});
        @(negedge clock);
        chk("rst_we", {63'b0, escreve_R}, 64'd0);
        chk("rst_addr", {59'b0, endereco_E}, 64'd0);
        chk("rst_data", {32'b0, dados}, 64'd0);
        chk("rst_busy", {63'b0, ocupado}, 64'd1);
        chk("rst_pronto_a", {63'b0, pronto_A}, 64'd0);
        chk("rst_busy_noinit", {63'b0, ocupado2}, 64'd0);
        chk("rst_pronto_a_noinit", {63'b0, pronto_A2}, 64'd1);
        #2 reset_n = 1'b1;
        w0 = writes_seen;
        n_busy = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (!ocupado) break;
            n_busy++;
            chk("clear_pronto_a", {63'b0, pronto_A}, 64'd0);
        end
        chk("clear_busy_cycles", 64'(n_busy), 64'd31);
        chk("clear_last_addr", {59'b0, endereco_E}, 64'd31);
        chk("clear_last_we", {63'b0, escreve_R}, 64'd1);
        chk("transition_pronto_a", {63'b0, pronto_A}, 64'd1);
        @(posedge clock); #1;
        req_A = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("t1_idle_we", {63'b0, escreve_R}, 64'd0);
        chk("t1_write_count", 64'(writes_seen - w0), 64'd33);

        // Test 2: single A write, one-cycle write pulse.
        send_a(5'd5, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("t2_we", {63'b0, escreve_R}, 64'd1);
        chk("t2_addr", {59'b0, endereco_E}, 64'd5);
        chk("t2_data", {32'b0, dados}, 64'hDEAD_BEEF);
        @(negedge clock);
        chk("t2_we_drop", {63'b0, escreve_R}, 64'd0);

        // Test 4: B writes $0 -> accepted, discarded.
        send_b(5'd0, 32'hFFFF_FFFF);
        @(negedge clock);
        chk("t4_no_write", {63'b0, escreve_R}, 64'd0);

        // Test 3: both held; last transfer was B so A wins first.
        @(posedge clock); #1;
        req_A = 1'b1; end_A = 5'd3; dados_A = 32'h1111_1111;
        req_B = 1'b1; end_B = 5'd4; dados_B = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i % 2 == 0) begin
                chk("rr_pronto_a", {63'b0, pronto_A}, 64'd1);
                chk("rr_pronto_b", {63'b0, pronto_B}, 64'd0);
                exp_q.push_back({5'd3, 32'h1111_1111});
            end else begin
                chk("rr_pronto_a", {63'b0, pronto_A}, 64'd0);
                chk("rr_pronto_b", {63'b0, pronto_B}, 64'd1);
                exp_q.push_back({5'd4, 32'h2222_2222});
            end
        end
        @(posedge clock); #1;
        req_A = 1'b0; req_B = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("t3_idle_we", {63'b0, escreve_R}, 64'd0);

        // Test 5: stale-read flags.
        endereco_L1 = 5'd7; endereco_L2 = 5'd0;
        send_a(5'd7, 32'h7777_7777);
        @(negedge clock);
        chk("conf_l1_hit", {63'b0, conflito_L1}, 64'd1);
        chk("conf_l2_zero", {63'b0, conflito_L2}, 64'd0);
        @(negedge clock);
        chk("conf_l1_idle", {63'b0, conflito_L1}, 64'd0);
        endereco_L1 = '0;

        // Test 6: reset in the middle of a clear.
        @(posedge clock); #1;
        reset_n = 1'b0;
        exp_q.delete();
        push_clear();
        #2 reset_n = 1'b1;
        found = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (escreve_R && endereco_E == 5'd10) begin found = 1; break; end
        end
        chk("t6_reach_addr10", {63'b0, found}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_we", {63'b0, escreve_R}, 64'd0);
        chk("t6_rst_addr", {59'b0, endereco_E}, 64'd0);
        chk("t6_rst_data", {32'b0, dados}, 64'd0);
        chk("t6_rst_busy", {63'b0, ocupado}, 64'd1);
        exp_q.delete();
        push_clear();
        req_A = 1'b1; end_A = 5'd0; dados_A = 32'h0BAD_0000;
        endereco_L1 = 5'd3;
        w0 = writes_seen;
        @(negedge clock);
        #2 reset_n = 1'b1;
        chk("t6_noinit_busy", {63'b0, ocupado2}, 64'd0);
        chk("t6_noinit_pronto", {63'b0, pronto_A2}, 64'd1);
        chk("t6_init_pronto", {63'b0, pronto_A}, 64'd0);
        @(posedge clock); #1;
        req_A = 1'b0;
        n_conf = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (conflito_L1) n_conf++;
            if (!ocupado) break;
        end
        @(negedge clock);
        chk("t6_clear_writes", 64'(writes_seen - w0), 64'd32);
        chk("t6_clear_conflicts", 64'(n_conf), 64'd1);
        chk("t6_idle_we", {63'b0, escreve_R}, 64'd0);
        endereco_L1 = '0;

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controle_escrita_registradores.md
Name: controle_escrita_registradores

Overview:
Write-port controller and arbiter for the 32x32 register file, which has one write port and no reset. Shares that single write port between two writeback requesters: A (ULA) and B (memória/E-S), using a valid/ready handshake and round-robin arbitration. After reset it clears every register by sequencing zero-writes, and it flags stale same-cycle reads for the hazard logic.

Parameters:
NUM_REGS, 32, number of registers to clear; must equal 2^END_LARG
END_LARG, 5, register address width
LARGURA, 32, data width
INICIALIZA, 1, 1 = run the clear sequence after reset; 0 = go straight to OPERA

Ports:
clock  in  1  single system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_A  in  1  requester A write request
end_A  in  END_LARG  requester A destination register
dados_A  in  LARGURA  requester A write data
pronto_A  out  1  grant/accept for A (combinational)
req_B  in  1  requester B write request
end_B  in  END_LARG  requester B destination register
dados_B  in  LARGURA  requester B write data
pronto_B  out  1  grant/accept for B (combinational)
endereco_E  out  END_LARG  register-file write address (registered)
dados  out  LARGURA  register-file write data (registered)
escreve_R  out  1  register-file write enable (registered)
ocupado  out  1  high while the clear sequence runs
endereco_L1  in  END_LARG  decoder read address RS
endereco_L2  in  END_LARG  decoder read address RT
conflito_L1  out  1  RS read returns stale data this cycle
conflito_L2  out  1  RT read returns stale data this cycle

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0), applied immediately:
  - escreve_R=0, endereco_E=0, dados=0, contador=0.
  - ultimo=B, so A wins the first tie.
  - estado=LIMPA if INICIALIZA=1, else OPERA.
  - ocupado = (estado==LIMPA).
- Reset asserted mid-clear: outputs return to reset values at once; the clear restarts from address 0 after release.
- State LIMPA:
  - pronto_A=pronto_B=0.
  - Each posedge loads endereco_E<=contador, dados<=0, escreve_R<=1, then contador++.
  - The posedge that loads contador=NUM_REGS-1 also moves estado to OPERA.
  - escreve_R is therefore high for exactly NUM_REGS consecutive cycles (addresses 0..31). Register 0 is included in the clear.
- State OPERA:
  - Only A requesting: pronto_A=1.
  - Only B requesting: pronto_B=1.
  - Both requesting: grant the requester that is not ultimo.
  - Neither requesting: both pronto low.
  - At most one pronto is high per cycle.
  - A transfer is req_X && pronto_X. On a transfer, ultimo<=X.
  - Requesters hold req/end/dados stable until pronto; dropping req without a transfer is allowed.
- Write path:
  - Transfer with end_X!=0: at the next posedge, endereco_E<=end_X, dados<=dados_X, escreve_R<=1.
  - Otherwise escreve_R<=0, and endereco_E/dados hold their values.
  - Latency: handshake cycle n -> escreve_R high in cycle n+1 -> register file updated at the end of n+1.
- Register $0 in OPERA: a write to address 0 is accepted (pronto high, ultimo updates) but discarded (escreve_R stays 0).
- The transition cycle (last clear write on the outputs, estado=OPERA) may accept a request; that write appears the following cycle.
- conflito_Lx = escreve_R && (endereco_E==endereco_Lx) && (endereco_Lx!=0). It is combinational and is also valid during LIMPA.
- No internal buffering: back-pressure comes only through pronto.

Test Plan:
1. Reset release, INICIALIZA=1, req_A held high -> escreve_R high 32 cycles with endereco_E 0..31 and dados=0; ocupado drops on the cycle the outputs show address 31; pronto_A=0 throughout the clear, then 1.
2. After clear, A: end_A=5, dados_A=0xDEADBEEF for one cycle -> next cycle endereco_E=5, dados=0xDEADBEEF, escreve_R=1; cycle after that escreve_R=0.
3. A (end 3, 0x11111111) and B (end 4, 0x22222222) both held for 4 cycles, each re-presenting after grant -> grants A,B,A,B; escreve_R addresses 3,4,3,4 one cycle later.
4. B writes end_B=0, dados_B=0xFFFFFFFF -> pronto_B=1; escreve_R stays 0; next tie goes to A.
5. Output shows write to 7; endereco_L1=7, endereco_L2=0 -> conflito_L1=1, conflito_L2=0. Next idle cycle -> conflito_L1=0.
6. reset_n pulsed low while the clear is at address 10 -> escreve_R/endereco_E/dados drop to 0 immediately; after release the clear restarts at 0 and takes a full 32 cycles; with INICIALIZA=0 -> ocupado=0 and pronto available in the first cycle.
